// File: rtl/phase_pkg.sv
// Shared phase encoding, monitor states and helpers for the PHASE stream checker.
package phase_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    UPDATE = 2'b11
  } STATES;

  typedef enum logic [1:0] {
    SYNC  = 2'b00,
    TRACK = 2'b01,
    ERROR = 2'b10
  } MON_STATES;

  // Wide enough for the largest allowed stall limit (255).
  localparam int STALL_W = 8;

  typedef struct packed {
    STATES exp;
    STATES got;
  } err_cap_t;

  // Phaser advances one phase per enabled cycle and wraps UPDATE -> FETCH.
  function automatic STATES next_phase(STATES p, bit en);
    logic [1:0] n;
    n = p + {1'b0, en};
    return STATES'(n);
  endfunction

endpackage

// File: rtl/phase_stall_timer.sv
// Saturating EN-low counter; stall is high once the count reaches LIMIT.
module phase_stall_timer
  import phase_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic clr,
  input  logic inc,
  output logic stall
);

  localparam logic [STALL_W-1:0] LIM = STALL_W'(LIMIT);

  logic [STALL_W-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != LIM) cnt <= cnt + STALL_W'(1);
  end

  assign stall = (cnt == LIM);

endmodule

// File: rtl/phase_monitor.sv
// Passive checker for the phaser PHASE/EN stream: strobes, cycle count, error/stall flags.
// Optional: define PHASE_MON_AUTOSYNC_EN to let ERROR resync on its own at the next FETCH.
module phase_monitor
  import phase_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       PHASE,
  input  logic             ERR_CLR,
  output logic             FETCH_STB,
  output logic             DECODE_STB,
  output logic             EXEC_STB,
  output logic             UPDATE_STB,
  output logic             CYCLE_DONE,
  output logic [CNT_W-1:0] CYCLE_CNT,
  output logic             SEQ_ERR,
  output logic [1:0]       ERR_EXP,
  output logic [1:0]       ERR_GOT,
  output logic             STALL,
  output logic             SYNCED
);

  MON_STATES        state, next_state;
  STATES            phase, prev_phase, expected;
  logic             prev_en;
  logic [3:0]       stb;
  logic             cycle_done;
  logic [CNT_W-1:0] cycle_cnt;
  logic             seq_err;
  err_cap_t         err_cap;
  logic             mismatch, wrap;
  logic             stall_clr, stall;

  assign phase    = STATES'(PHASE);
  assign expected = next_phase(prev_phase, prev_en);
  assign mismatch = (state == TRACK) && (phase != expected);
  // A legal UPDATE->FETCH can only happen with prev_en high, so no extra EN term.
  assign wrap     = (state == TRACK) && !mismatch && !ERR_CLR &&
                    (prev_phase == UPDATE) && (phase == FETCH);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= SYNC;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SYNC:  if (phase == FETCH) next_state = TRACK;
      TRACK: if (mismatch)       next_state = ERROR;
      ERROR: begin
`ifdef PHASE_MON_AUTOSYNC_EN
        if (phase == FETCH) next_state = TRACK;
`endif
      end
      default: next_state = SYNC;
    endcase
    if (ERR_CLR) next_state = SYNC;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_phase <= FETCH;
      prev_en    <= 1'b0;
      stb        <= '0;
    end else begin
      prev_phase <= phase;
      prev_en    <= EN;
      stb        <= 4'b0001 << PHASE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cycle_done <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      cycle_done <= wrap;
      if (wrap) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  // First error wins: capture only while the sticky flag is still clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      seq_err <= 1'b0;
      err_cap <= '{exp: FETCH, got: FETCH};
    end else if (ERR_CLR) begin
      seq_err <= 1'b0;
      err_cap <= '{exp: FETCH, got: FETCH};
    end else if (mismatch) begin
      seq_err <= 1'b1;
      if (!seq_err) err_cap <= '{exp: expected, got: phase};
    end
  end

  assign stall_clr = ERR_CLR || (state != TRACK) || EN;

  phase_stall_timer #(
    .LIMIT (STALL_LIMIT)
  ) u_stall (
    .gclk   (CLK),
    .grst_n (RST),
    .clr    (stall_clr),
    .inc    (!EN),
    .stall  (stall)
  );

  assign FETCH_STB  = stb[0];
  assign DECODE_STB = stb[1];
  assign EXEC_STB   = stb[2];
  assign UPDATE_STB = stb[3];
  assign CYCLE_DONE = cycle_done;
  assign CYCLE_CNT  = cycle_cnt;
  assign SEQ_ERR    = seq_err;
  assign ERR_EXP    = err_cap.exp;
  assign ERR_GOT    = err_cap.got;
  assign STALL      = stall;
  assign SYNCED     = (state == TRACK);

endmodule

// File: tb/tb_phase_monitor.sv
// Directed bench for phase_monitor (CNT_W=4 so the counter wrap is reachable quickly).
module tb_phase_monitor;

  logic       CLK = 1'b0;
  logic       RST, EN, ERR_CLR;
  logic [1:0] PHASE;
  logic       FETCH_STB, DECODE_STB, EXEC_STB, UPDATE_STB;
  logic       CYCLE_DONE, SEQ_ERR, STALL, SYNCED;
  logic [3:0] CYCLE_CNT;
  logic [1:0] ERR_EXP, ERR_GOT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  phase_monitor #(.CNT_W(4), .STALL_LIMIT(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .PHASE      (PHASE),
    .ERR_CLR    (ERR_CLR),
    .FETCH_STB  (FETCH_STB),
    .DECODE_STB (DECODE_STB),
    .EXEC_STB   (EXEC_STB),
    .UPDATE_STB (UPDATE_STB),
    .CYCLE_DONE (CYCLE_DONE),
    .CYCLE_CNT  (CYCLE_CNT),
    .SEQ_ERR    (SEQ_ERR),
    .ERR_EXP    (ERR_EXP),
    .ERR_GOT    (ERR_GOT),
    .STALL      (STALL),
    .SYNCED     (SYNCED)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic [1:0] ph);
    EN = en;
    PHASE = ph;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] stbs();
    return {UPDATE_STB, EXEC_STB, DECODE_STB, FETCH_STB};
  endfunction

  initial begin
    bit         autosync;
    int         pulses;
    logic [3:0] ecnt;
`ifdef PHASE_MON_AUTOSYNC_EN
    autosync = 1'b1;
`else
    autosync = 1'b0;
`endif
    RST = 1'b0; EN = 1'b0; PHASE = 2'b00; ERR_CLR = 1'b0;
    #1;
    chk("rst_stb", stbs(), 4'b0000);
    chk("rst_synced", SYNCED, 0);
    chk("rst_cnt", CYCLE_CNT, 0);
    @(posedge CLK); @(posedge CLK); #1;
    chk("rst_hold_stb", stbs(), 4'b0000);
    chk("rst_hold_err", {SEQ_ERR, ERR_EXP, ERR_GOT, STALL, CYCLE_DONE}, 0);
    RST = 1'b1;

    // Clean run 0,1,2,3,0,1,2,3
    cyc(1, 2'd0); chk("a_synced", SYNCED, 1); chk("a_stb0", stbs(), 4'b0001);
    cyc(1, 2'd1); chk("a_stb1", stbs(), 4'b0010);
    cyc(1, 2'd2); chk("a_stb2", stbs(), 4'b0100);
    cyc(1, 2'd3); chk("a_stb3", stbs(), 4'b1000); chk("a_done0", CYCLE_DONE, 0);
    cyc(1, 2'd0); chk("a_done1", CYCLE_DONE, 1); chk("a_cnt1", CYCLE_CNT, 1);
    cyc(1, 2'd1); chk("a_done_pulse", CYCLE_DONE, 0);
    cyc(1, 2'd2);
    cyc(1, 2'd3); chk("a_cnt_end", CYCLE_CNT, 1); chk("a_noerr", SEQ_ERR, 0);

    // Short EN-low hold at EXEC, then a long one at FETCH
    cyc(1, 2'd0); chk("b_cnt2", CYCLE_CNT, 2);
    cyc(1, 2'd1);
    cyc(0, 2'd2);
    cyc(0, 2'd2);
    cyc(0, 2'd2); chk("b_hold_noerr", SEQ_ERR, 0); chk("b_hold_nostall", STALL, 0);
    chk("b_hold_stb", stbs(), 4'b0100); chk("b_hold_synced", SYNCED, 1);
    cyc(1, 2'd2);
    cyc(1, 2'd3);
    cyc(0, 2'd0); chk("b_done", CYCLE_DONE, 1); chk("b_cnt3", CYCLE_CNT, 3);
    chk("b_stall_k1", STALL, 0);
    for (int k = 2; k <= 10; k++) begin
      cyc(0, 2'd0);
      chk($sformatf("b_stall_k%0d", k), STALL, (k >= 8) ? 1 : 0);
    end
    chk("b_long_noerr", SEQ_ERR, 0);
    EN = 1'b1; PHASE = 2'd0; #1;
    chk("b_stall_held", STALL, 1);
    @(posedge CLK); #1;
    chk("b_stall_drop", STALL, 0);

    // Illegal DECODE->UPDATE, sticky capture
    cyc(1, 2'd1);
    cyc(1, 2'd3);
    chk("c_err", SEQ_ERR, 1); chk("c_exp", ERR_EXP, 2'b10); chk("c_got", ERR_GOT, 2'b11);
    chk("c_unsynced", SYNCED, 0);
    cyc(1, 2'd1);
    chk("c_exp_hold", ERR_EXP, 2'b10); chk("c_got_hold", ERR_GOT, 2'b11);
    cyc(1, 2'd0);
    chk("c_autosync", SYNCED, autosync ? 1 : 0); chk("c_err_sticky", SEQ_ERR, 1);
    cyc(1, 2'd3);
    chk("c_exp_first", ERR_EXP, 2'b10); chk("c_got_first", ERR_GOT, 2'b11);
    chk("c_synced2", SYNCED, 0); chk("c_cnt", CYCLE_CNT, 3);

    // ERR_CLR clears everything but the count
    ERR_CLR = 1'b1;
    cyc(1, 2'd0);
    ERR_CLR = 1'b0;
    chk("d_clr_err", SEQ_ERR, 0); chk("d_clr_cap", {ERR_EXP, ERR_GOT}, 4'b0000);
    chk("d_clr_synced", SYNCED, 0); chk("d_clr_cnt", CYCLE_CNT, 3);
    cyc(1, 2'd0); chk("d_resync", SYNCED, 1);
    cyc(1, 2'd1);
    ERR_CLR = 1'b1;
    cyc(1, 2'd3);
    ERR_CLR = 1'b0;
    chk("d_clr_wins", SEQ_ERR, 0); chk("d_clr_wins_got", ERR_GOT, 0);
    chk("d_clr_wins_sync", SYNCED, 0);

    // 17 full cycles on a 4-bit counter, starting from 3
    cyc(1, 2'd0); chk("e_track", SYNCED, 1); chk("e_cnt0", CYCLE_CNT, 3);
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      cyc(1, 2'd1);
      cyc(1, 2'd2);
      cyc(1, 2'd3);
      cyc(1, 2'd0);
      pulses += int'(CYCLE_DONE);
      ecnt = 4'(3 + i + 1);
      chk($sformatf("e_cnt_i%0d", i), CYCLE_CNT, ecnt);
    end
    chk("e_pulses", pulses, 17);
    chk("e_wrap", CYCLE_CNT, 4);
    chk("e_noerr", SEQ_ERR, 0);

    // Asynchronous reset during EXEC
    cyc(1, 2'd1);
    cyc(1, 2'd2); chk("f_exec", stbs(), 4'b0100);
    #1 RST = 1'b0;
    #1;
    chk("f_async_stb", stbs(), 4'b0000); chk("f_async_sync", SYNCED, 0);
    chk("f_async_cnt", CYCLE_CNT, 0); chk("f_async_misc", {SEQ_ERR, STALL, CYCLE_DONE}, 0);
    #1 RST = 1'b1;
    cyc(1, 2'd1); chk("f_sync_dec", SYNCED, 0); chk("f_stb_dec", stbs(), 4'b0010);
    cyc(1, 2'd2); chk("f_sync_exec", SYNCED, 0);
    cyc(1, 2'd3);
    cyc(1, 2'd0); chk("f_sync_fetch", SYNCED, 1); chk("f_cnt", CYCLE_CNT, 0);

    // Advance after an EN-low cycle is illegal
    cyc(0, 2'd1); chk("g_ok", SEQ_ERR, 0);
    cyc(0, 2'd2);
    chk("g_err", SEQ_ERR, 1); chk("g_exp", ERR_EXP, 2'b01); chk("g_got", ERR_GOT, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
